// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = 32;
    localparam int ITER_W    = $clog2(MDU_ITER);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);
    logic [WIDTH-1:0] shifted_lo;

    // rem < divisor always holds, so after a successful subtract the result fits in WIDTH bits.
    assign shifted_lo = {rem[WIDTH-2:0], dbit};
    assign qbit       = ({rem, dbit} >= {1'b0, divisor});
    assign rem_next   = qbit ? (shifted_lo - divisor) : shifted_lo;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide: magnitudes are processed for ITER cycles, signs applied in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = MDU_ITER
) (
    input  logic             clck,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);
    // Handshake: start is only sampled in IDLE; a/b/op are captured on that edge, and
    // done (with div_zero for a zero divisor) pulses one cycle when hi/lo are final.
    state_t              state;
    logic [ITER_W-1:0]   cnt;
    logic                op_q;
    logic                sign_p;
    logic                sign_a;
    logic [WIDTH-1:0]    opnd;
    logic [2*WIDTH-1:0]  acc;

    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;
    logic [WIDTH:0]      mult_sum;
    logic [WIDTH-1:0]    rem_next;
    logic                qbit;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // acc holds {partial product, remaining multiplier} for mult and {remainder, dividend/quotient} for div.
    assign mult_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .dbit     (acc[WIDTH-1]),
        .divisor  (opnd),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    assign prod_fix  = sign_p ? -acc : acc;
    assign quo_fix   = sign_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign dbg_state = state;

    always_ff @(posedge clck or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= OP_MULT;
            sign_p   <= 1'b0;
            sign_a   <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_p <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_a <= a[WIDTH-1];
                        cnt    <= '0;
                        if (op == OP_DIV && b == '0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            opnd  <= (op == OP_DIV) ? abs_b : abs_a;
                            acc   <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? abs_a : abs_b)};
                        end
                    end
                end
                ST_RUN: begin
                    if (op_q == OP_MULT)
                        acc <= {mult_sum, acc[WIDTH-1:1]};
                    else
                        acc <= {rem_next, acc[WIDTH-2:0], qbit};
                    if (cnt == ITER_W'(ITER - 1))
                        state <= ST_FIX;
                    else
                        cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    if (op_q == OP_MULT) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, random signed vectors and multi-cycle corner sequences.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    logic         clck = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    int n_chk = 0;
    int n_fail = 0;
    logic [2*W:0] exp_q[$];
    vec_t vecs[13];

    mult_div_unit dut (
        .clck      (clck),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    always #5 clck = ~clck;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard: every done pops one expected {div_zero, hi, lo}.
    always @(negedge clck) begin
        if (reset_n && done) begin
            chk("done_has_request", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                chk("div_zero", 64'(div_zero), 64'(e[2*W]));
                chk("hi", 64'(hi), 64'(e[2*W-1:W]));
                chk("lo", 64'(lo), 64'(e[W-1:0]));
            end
        end
    end

    task automatic run_op(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          input int repulse_at);
        int lat;
        int busy_cnt;
        @(negedge clck);
        op = o; a = ia; b = ib; start = 1'b1;
        exp_q.push_back({edz, ehi, elo});
        @(negedge clck);
        start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            if (i > 1) @(negedge clck);
            if (busy) busy_cnt++;
            if (done) lat = i;
            if (i == repulse_at) begin
                start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
            end
            if (i == repulse_at + 1) start = 1'b0;
        end
        chk("latency", 64'(lat), edz ? 64'(1) : 64'(34));
        chk("busy_cycles", 64'(busy_cnt), edz ? 64'(0) : 64'(33));
        @(negedge clck);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("back_to_idle", 64'(dbg_state), 64'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_MULT, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[2]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[3]  = '{OP_MULT, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[4]  = '{OP_DIV,  32'd0,          32'd9,        32'h00000000, 32'h00000000, 1'b0};
        vecs[5]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{OP_MULT, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[7]  = '{OP_MULT, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[8]  = '{OP_DIV,  32'd100,        32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[9]  = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        vecs[10] = '{OP_MULT, 32'h12345678,   32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        // Divide by zero keeps the previous hi/lo.
        vecs[11] = '{OP_DIV,  32'd5,          32'd0,        32'h00000001, 32'h23456780, 1'b1};
        vecs[12] = '{OP_MULT, 32'd3,          32'd5,        32'h00000000, 32'h0000000F, 1'b0};

        @(negedge clck);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_div_zero", 64'(div_zero), 64'(0));
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clck);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 0);

        // Random signed vectors against the simulator's own arithmetic.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            longint p;
            int q, r;
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                p = longint'($signed(ra)) * longint'($signed(rb));
                run_op(OP_MULT, ra, rb, p[63:32], p[31:0], 1'b0, 0);
            end else begin
                if (i == 3) rb = 32'(int'($urandom_range(1, 50)));
                if (rb == '0 || (ra == 32'h80000000 && rb == 32'hFFFFFFFF)) rb = 32'd3;
                q = $signed(ra) / $signed(rb);
                r = $signed(ra) % $signed(rb);
                run_op(OP_DIV, ra, rb, r, q, 1'b0, 0);
            end
        end

        // Restart pulse during a running mult must be ignored.
        run_op(OP_MULT, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFFFF, 32'hFFFFD8F0, 1'b0, 9);

        // Reset in the middle of a divide.
        @(negedge clck);
        op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clck);
        start = 1'b0;
        repeat (13) @(negedge clck);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'(0));
        chk("midreset_done", 64'(done), 64'(0));
        chk("midreset_hi", 64'(hi), 64'(0));
        chk("midreset_lo", 64'(lo), 64'(0));
        chk("midreset_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(negedge clck);
        reset_n = 1'b1;
        repeat (40) @(negedge clck);
        chk("no_done_after_reset", 64'(exp_q.size()), 64'(0));
        run_op(OP_DIV, 32'hFFFFFC18, 32'd3, 32'hFFFFFFFF, 32'hFFFFFEB3, 1'b0, 0);

        repeat (3) @(negedge clck);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
